// File: rtl/wptr_full_ctrl_if.sv
// Write-side bus of the async FIFO pointer controller: requests and the
// synchronized read pointer in, RAM address, Gray pointer and status out.
interface wptr_full_ctrl_if #(
  parameter int ADDRSIZE = 4,
  parameter int DROPW    = 8
);
  logic                winc;
  logic [ADDRSIZE:0]   wq2_rptr;
  logic [ADDRSIZE:0]   afull_thresh;
  logic                wovf_clr;
  logic [ADDRSIZE-1:0] waddr;
  logic [ADDRSIZE:0]   wptr;
  logic                wfull;
  logic                walmost_full;
  logic [ADDRSIZE:0]   wlevel;
  logic                wovf;
  logic [DROPW-1:0]    wdrop_cnt;

  modport master (
    output winc, wq2_rptr, afull_thresh, wovf_clr,
    input  waddr, wptr, wfull, walmost_full, wlevel, wovf, wdrop_cnt
  );

  modport slave (
    input  winc, wq2_rptr, afull_thresh, wovf_clr,
    output waddr, wptr, wfull, walmost_full, wlevel, wovf, wdrop_cnt
  );
endinterface

// File: rtl/wptr_full_ctrl.sv
// Write-domain pointer and status controller of the async FIFO: binary/Gray
// write pointer, full / almost-full / level flags and overflow diagnostics.
module wptr_full_ctrl #(
  parameter int ADDRSIZE = 4,
  parameter int DROPW    = 8
) (
  input  logic              wclk,
  input  logic              wrst,
  wptr_full_ctrl_if.slave   bus
);

  localparam logic [DROPW-1:0] DROP_MAX = {DROPW{1'b1}};

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wptr_q;
  logic              wfull_q;
  logic              walmost_full_q;
  logic [ADDRSIZE:0] wlevel_q;
  logic              wovf_q;
  logic [DROPW-1:0]  wdrop_cnt_q;

  logic              wen;
  logic              wdrop;
  logic [ADDRSIZE:0] wbin_next;
  logic [ADDRSIZE:0] wgray_next;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] level_next;
  logic [ADDRSIZE:0] full_match;
  logic              full_next;
  logic              afull_next;

  // Accept/drop decisions deliberately use the registered full flag.
  always_comb begin
    wen        = bus.winc & ~wfull_q;
    wdrop      = bus.winc & wfull_q;
    wbin_next  = wbin + (ADDRSIZE+1)'(wen);
    wgray_next = (wbin_next >> 1) ^ wbin_next;
  end

  // Full when the next write pointer is exactly one lap ahead of the read pointer.
  always_comb begin
    full_match = {~bus.wq2_rptr[ADDRSIZE:ADDRSIZE-1], bus.wq2_rptr[ADDRSIZE-2:0]};
    full_next  = (wgray_next == full_match);
  end

  always_comb begin
    rbin_s           = '0;
    rbin_s[ADDRSIZE] = bus.wq2_rptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      rbin_s[i] = rbin_s[i+1] ^ bus.wq2_rptr[i];
    end
  end

  always_comb begin
    level_next = wbin_next - rbin_s;
    afull_next = (bus.afull_thresh != '0) && (level_next >= bus.afull_thresh);
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wbin           <= '0;
      wptr_q         <= '0;
      wfull_q        <= 1'b0;
      walmost_full_q <= 1'b0;
      wlevel_q       <= '0;
    end else begin
      wbin           <= wbin_next;
      wptr_q         <= wgray_next;
      wfull_q        <= full_next;
      walmost_full_q <= afull_next;
      wlevel_q       <= level_next;
    end
  end

  // A drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      wovf_q      <= 1'b0;
      wdrop_cnt_q <= '0;
    end else if (wdrop) begin
      wovf_q <= 1'b1;
      if (bus.wovf_clr) begin
        wdrop_cnt_q <= DROPW'(1);
      end else if (wdrop_cnt_q != DROP_MAX) begin
        wdrop_cnt_q <= wdrop_cnt_q + DROPW'(1);
      end
    end else if (bus.wovf_clr) begin
      wovf_q      <= 1'b0;
      wdrop_cnt_q <= '0;
    end
  end

  assign bus.waddr        = wbin[ADDRSIZE-1:0];
  assign bus.wptr         = wptr_q;
  assign bus.wfull        = wfull_q;
  assign bus.walmost_full = walmost_full_q;
  assign bus.wlevel       = wlevel_q;
  assign bus.wovf         = wovf_q;
  assign bus.wdrop_cnt    = wdrop_cnt_q;

endmodule

// File: tb/tb_wptr_full_ctrl.sv
// Scoreboard bench for wptr_full_ctrl: stimulus pushes expectations from an
// occupancy-count model, a monitor pops and compares after every edge.
module tb_wptr_full_ctrl;

  localparam int A     = 4;
  localparam int D     = 8;
  localparam int DEPTH = 1 << A;
  localparam int PMOD  = 1 << (A + 1);
  localparam int DMAX  = (1 << D) - 1;

  typedef struct {
    int waddr;
    int wptr;
    int wfull;
    int wafull;
    int wlevel;
    int wovf;
    int wdrop;
  } exp_t;

  logic wclk;
  logic wrst;
  exp_t exp_q[$];
  int   checks;
  int   errors;

  // Model state: total words written/read since reset, plus registered flags.
  int   w_total;
  int   r_total;
  bit   m_full;
  bit   m_ovf;
  int   m_drop;

  wptr_full_ctrl_if #(.ADDRSIZE(A), .DROPW(D)) bus ();

  wptr_full_ctrl #(.ADDRSIZE(A), .DROPW(D)) dut (
    .wclk (wclk),
    .wrst (wrst),
    .bus  (bus)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check_val(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d required=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic model_reset();
    w_total = 0;
    r_total = 0;
    m_full  = 1'b0;
    m_ovf   = 1'b0;
    m_drop  = 0;
  endtask

  // Drive one cycle of inputs and push the state expected after the next edge.
  task automatic applyStimulus(input bit winc, input bit radv, input int thresh, input bit clr);
    exp_t e;
    int   occ;
    int   wb;
    bit   wen;
    bit   drop;
    @(negedge wclk);
    if (radv && r_total < w_total) r_total++;
    bus.winc         = winc;
    bus.wq2_rptr     = (A+1)'(to_gray(r_total % PMOD));
    bus.afull_thresh = (A+1)'(thresh);
    bus.wovf_clr     = clr;
    wen  = winc && !m_full;
    drop = winc && m_full;
    if (wen) w_total++;
    occ = w_total - r_total;
    wb  = w_total % PMOD;
    if (drop) begin
      m_ovf  = 1'b1;
      m_drop = clr ? 1 : ((m_drop < DMAX) ? m_drop + 1 : DMAX);
    end else if (clr) begin
      m_ovf  = 1'b0;
      m_drop = 0;
    end
    m_full   = (occ == DEPTH);
    e.waddr  = w_total % DEPTH;
    e.wptr   = to_gray(wb);
    e.wfull  = int'(m_full);
    e.wlevel = occ;
    e.wafull = (thresh != 0 && occ >= thresh) ? 1 : 0;
    e.wovf   = int'(m_ovf);
    e.wdrop  = m_drop;
    exp_q.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    check_val("waddr",        int'(bus.waddr),        e.waddr);
    check_val("wptr",         int'(bus.wptr),         e.wptr);
    check_val("wfull",        int'(bus.wfull),        e.wfull);
    check_val("walmost_full", int'(bus.walmost_full), e.wafull);
    check_val("wlevel",       int'(bus.wlevel),       e.wlevel);
    check_val("wovf",         int'(bus.wovf),         e.wovf);
    check_val("wdrop_cnt",    int'(bus.wdrop_cnt),    e.wdrop);
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_waddr"},  int'(bus.waddr),        0);
    check_val({tag, "_wptr"},   int'(bus.wptr),         0);
    check_val({tag, "_wfull"},  int'(bus.wfull),        0);
    check_val({tag, "_afull"},  int'(bus.walmost_full), 0);
    check_val({tag, "_wlevel"}, int'(bus.wlevel),       0);
    check_val({tag, "_wovf"},   int'(bus.wovf),         0);
    check_val({tag, "_wdrop"},  int'(bus.wdrop_cnt),    0);
  endtask

  // Monitor: outputs are valid every cycle, so pop one expectation per edge.
  always @(posedge wclk) begin
    #2;
    if (!wrst && exp_q.size() > 0) begin
      checkOutput(exp_q.pop_front());
    end
  end

  task automatic drain(input int thresh);
    while (r_total < w_total) applyStimulus(1'b0, 1'b1, thresh, 1'b0);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    wrst             = 1'b1;
    bus.winc         = 1'b0;
    bus.wq2_rptr     = '0;
    bus.afull_thresh = '0;
    bus.wovf_clr     = 1'b0;
    model_reset();
    #22;
    check_all_zero("reset");
    @(negedge wclk);
    wrst = 1'b0;

    $display("[TB] fill to full and overflow");
    repeat (16) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    repeat (3)  applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b1);
    applyStimulus(1'b1, 1'b0, 0, 1'b1);

    $display("[TB] release one slot while full, then refill");
    applyStimulus(1'b0, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b1, 1'b1, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 0, 1'b0);

    $display("[TB] almost-full threshold 12, then disabled");
    drain(12);
    repeat (16) applyStimulus(1'b1, 1'b0, 12, 1'b0);
    drain(0);
    repeat (16) applyStimulus(1'b1, 1'b0, 0, 1'b0);
    applyStimulus(1'b0, 1'b0, 16, 1'b0);

    $display("[TB] drop counter saturation");
    repeat (DMAX + 5) applyStimulus(1'b1, 1'b0, 16, 1'b0);
    applyStimulus(1'b0, 1'b0, 16, 1'b1);

    $display("[TB] pointer wrap with reads keeping up");
    drain(0);
    repeat (40) applyStimulus(1'b1, 1'b1, 0, 1'b0);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom % 4) != 0, ($urandom % 3) == 0,
                    int'($urandom_range(0, DEPTH)), ($urandom % 16) == 0);
    end

    $display("[TB] asynchronous reset mid-stream");
    drain(0);
    repeat (7) applyStimulus(1'b1, 1'b0, 4, 1'b0);
    @(posedge wclk);
    #4;
    bus.winc         = 1'b0;
    bus.wq2_rptr     = '0;
    bus.afull_thresh = '0;
    bus.wovf_clr     = 1'b0;
    wrst             = 1'b1;
    #1;
    check_all_zero("async_reset");
    @(posedge wclk);
    @(negedge wclk);
    wrst = 1'b0;
    model_reset();
    check_val("post_reset_waddr", int'(bus.waddr), 0);
    repeat (5) applyStimulus(1'b1, 1'b0, 3, 1'b0);

    repeat (3) @(posedge wclk);
    #3;
    check_val("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
